sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO and the next generation of the team's 8-deep single-mode FIFO. Width, depth and almost-thresholds are generic. Adds an occupancy count, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in one clock domain. Keeps the existing status/handshake set (wr_ack, overflow, underflow, full, empty, almostfull, almostempty) so current monitors and scoreboards still apply.

---
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 tb/tb_sync_fifo_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, synchronous flush and
// a selectable read mode (registered read or first-word-fall-through).
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of contents; overrides wr_en/rd_en
//   wr_en        write request
//   data_in      write data
//   rd_en        read request
//   data_out     read data (registered when FWFT=0, head word when FWFT=1)
//   wr_ack       previous-cycle write was accepted
//   overflow     previous-cycle write was rejected because full
//   underflow    previous-cycle read was rejected because empty
//   full         count == FIFO_DEPTH
//   empty        count == 0
//   almostfull   count >= AF_LEVEL
//   almostempty  count <= AE_LEVEL
//   count        current occupancy
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Thresholds sized to the count so the flag compares are width-matched.
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags come straight from the occupancy count.
  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_CNT);
  assign almostempty = (count <= AE_CNT);

  // Accept decisions use pre-edge flags; flush suppresses both sides so a
  // flush cycle neither stores data nor moves the read pointer.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the one-cycle handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      wr_ack    <= wr_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; meaningless while empty.
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      // Registered read: data_out only changes on an accepted read, so it
      // holds through idle, rejected reads and flush.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out <= '0;
        end else if (rd_acc) begin
          data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// Directed bench for sync_fifo_param. One instance runs in registered-read
// mode, a second in first-word-fall-through mode with its own write/read
// controls; both share clock, reset and flush.
module tb_sync_fifo_param;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;

  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [3:0]  count;

  logic        f_wr_en = 1'b0;
  logic        f_rd_en = 1'b0;
  logic [W-1:0] f_data_in = '0;
  logic [W-1:0] f_data_out;
  logic        f_wr_ack, f_overflow, f_underflow, f_full, f_empty, f_af, f_ae;
  logic [3:0]  f_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .count(count)
  );

  sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en), .data_out(f_data_out),
    .wr_ack(f_wr_ack), .overflow(f_overflow), .underflow(f_underflow),
    .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
    .count(f_count)
  );

  // Advance one clock and settle just after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || almostempty !== 1'b1 || full !== 1'b0 || almostfull !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: count=%0d empty=%b ae=%b full=%b af=%b, need 0 1 1 0 0",
               count, empty, almostempty, full, almostfull);
    end
    tests++;
    if (wr_ack !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || data_out !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: wr_ack=%b ovf=%b udf=%b data_out=%h, need 0 0 0 0000",
               wr_ack, overflow, underflow, data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      data_in = W'(i);
      tick();
      tests++;
      if (wr_ack !== 1'b1 || count !== 4'(i) || almostfull !== (i >= 7) || full !== (i == 8)) begin
        fails++;
        $display("[TB] FAIL fill_%0d: wr_ack=%b count=%0d af=%b full=%b, need 1 %0d %b %b",
                 i, wr_ack, count, almostfull, full, i, (i >= 7), (i == 8));
      end
    end
    data_in = 16'h0009;
    tick();
    wr_en = 1'b0;
    tests++;
    if (overflow !== 1'b1 || wr_ack !== 1'b0 || count !== 4'd8) begin
      fails++;
      $display("[TB] FAIL fill_overflow: ovf=%b wr_ack=%b count=%0d, need 1 0 8", overflow, wr_ack, count);
    end
    tick();
    tests++;
    if (overflow !== 1'b0 || count !== 4'd8) begin
      fails++;
      $display("[TB] FAIL overflow_clear: ovf=%b count=%0d, need 0 8", overflow, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      tests++;
      if (data_out !== W'(i) || count !== 4'(8 - i)) begin
        fails++;
        $display("[TB] FAIL drain_%0d: data_out=%h count=%0d, need %h %0d", i, data_out, count, W'(i), 8 - i);
      end
    end
    tests++;
    if (empty !== 1'b1 || almostempty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL drain_empty: empty=%b ae=%b, need 1 1", empty, almostempty);
    end
    tick();
    rd_en = 1'b0;
    tests++;
    if (underflow !== 1'b1 || data_out !== 16'h0008 || count !== 4'd0) begin
      fails++;
      $display("[TB] FAIL drain_underflow: udf=%b data_out=%h count=%0d, need 1 0008 0", underflow, data_out, count);
    end
    tick();
    tests++;
    if (underflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL underflow_clear: udf=%b, need 0", underflow);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      data_in = W'(16'h0010 + i);
      tick();
    end
    // Full: read wins, write rejected.
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 16'h00FF;
    tick();
    tests++;
    if (overflow !== 1'b1 || wr_ack !== 1'b0 || count !== 4'd7 || data_out !== 16'h0011) begin
      fails++;
      $display("[TB] FAIL simul_full: ovf=%b wr_ack=%b count=%0d data_out=%h, need 1 0 7 0011",
               overflow, wr_ack, count, data_out);
    end
    wr_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      tests++;
      if (data_out !== W'(16'h0010 + i)) begin
        fails++;
        $display("[TB] FAIL simul_drain_%0d: data_out=%h, need %h", i, data_out, W'(16'h0010 + i));
      end
    end
    // Empty: write wins, read rejected.
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 16'h0055;
    tick();
    tests++;
    if (wr_ack !== 1'b1 || underflow !== 1'b1 || count !== 4'd1 || data_out !== 16'h0018) begin
      fails++;
      $display("[TB] FAIL simul_empty: wr_ack=%b udf=%b count=%0d data_out=%h, need 1 1 1 0018",
               wr_ack, underflow, count, data_out);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = W'(16'h0056 + i);
      tick();
    end
    // Mid-level: both accepted, count unchanged.
    rd_en = 1'b1;
    data_in = 16'h0059;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    tests++;
    if (count !== 4'd4 || wr_ack !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || data_out !== 16'h0055) begin
      fails++;
      $display("[TB] FAIL simul_mid: count=%0d wr_ack=%b ovf=%b udf=%b data_out=%h, need 4 1 0 0 0055",
               count, wr_ack, overflow, underflow, data_out);
    end
  endtask

  task automatic test_flush();
    wr_en = 1'b1;
    data_in = 16'h005A;
    tick();
    tests++;
    if (count !== 4'd5) begin
      fails++;
      $display("[TB] FAIL flush_pre: count=%0d, need 5", count);
    end
    flush = 1'b1;
    data_in = 16'h00EE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || wr_ack !== 1'b0 || data_out !== 16'h0055) begin
      fails++;
      $display("[TB] FAIL flush: count=%0d empty=%b wr_ack=%b data_out=%h, need 0 1 0 0055",
               count, empty, wr_ack, data_out);
    end
  endtask

  task automatic test_wrap();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = W'(16'h0200 + i);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = W'(16'h0203 + k);
      tick();
      tests++;
      if (data_out !== W'(16'h0200 + k) || count !== 4'd3) begin
        fails++;
        $display("[TB] FAIL wrap_%0d: data_out=%h count=%0d, need %h 3", k, data_out, count, W'(16'h0200 + k));
      end
    end
    wr_en = 1'b0;
    for (int k = 20; k < 23; k++) begin
      tick();
      tests++;
      if (data_out !== W'(16'h0200 + k)) begin
        fails++;
        $display("[TB] FAIL wrap_tail_%0d: data_out=%h, need %h", k, data_out, W'(16'h0200 + k));
      end
    end
    rd_en = 1'b0;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_empty: empty=%b, need 1", empty);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1;
    f_data_in = 16'hABCD;
    tick();
    f_wr_en = 1'b0;
    tests++;
    if (f_empty !== 1'b0 || f_data_out !== 16'hABCD || f_count !== 4'd1) begin
      fails++;
      $display("[TB] FAIL fwft_head: empty=%b data_out=%h count=%0d, need 0 abcd 1", f_empty, f_data_out, f_count);
    end
    tick();
    tests++;
    if (f_data_out !== 16'hABCD) begin
      fails++;
      $display("[TB] FAIL fwft_hold: data_out=%h, need abcd", f_data_out);
    end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    tests++;
    if (f_empty !== 1'b1 || f_count !== 4'd0) begin
      fails++;
      $display("[TB] FAIL fwft_pop: empty=%b count=%0d, need 1 0", f_empty, f_count);
    end
    f_wr_en = 1'b1;
    f_data_in = 16'h1111;
    tick();
    f_data_in = 16'h2222;
    tick();
    f_wr_en = 1'b0;
    f_rd_en = 1'b1;
    tests++;
    if (f_data_out !== 16'h1111) begin
      fails++;
      $display("[TB] FAIL fwft_first: data_out=%h, need 1111", f_data_out);
    end
    tick();
    f_rd_en = 1'b0;
    tests++;
    if (f_data_out !== 16'h2222 || f_count !== 4'd1) begin
      fails++;
      $display("[TB] FAIL fwft_next: data_out=%h count=%0d, need 2222 1", f_data_out, f_count);
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1;
    data_in = 16'h0777;
    tick();
    tick();
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || f_count !== 4'd0 || wr_ack !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: count=%0d empty=%b f_count=%0d wr_ack=%b, need 0 1 0 0",
               count, empty, f_count, wr_ack);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
